dw_fifo_s1_sf: RTL and testbench

Single-clock, synchronous-reset FIFO with first-word-fall-through read, registered occupancy flags and an overflow/underflow error output. It serves as the read-data queue in the VRF read pipe, buffering 32-bit VRF read results until the downstream consumer pops them. Depth, width, flag thresholds, error behaviour and memory-reset behaviour are parameters.

---
 rtl/dw_fifo_s1_sf.sv | 134 +++++++++++++
 tb/tb_dw_fifo_s1_sf.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dw_fifo_s1_sf.sv
// Single-clock FIFO, first-word-fall-through read, flags decoded from registered occupancy, overflow/underflow error.
// Latency: a word pushed at edge N is visible on data_out after edge N once it is the head; flags follow one edge after the cause.
// Backpressure: a push while full is dropped (overflow), a pop while empty is ignored (underflow); no input-to-output combinational path.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   push_req_n, pop_req_n active-low push / pop requests
//   diag_n                active-low clear of the sticky error (err_mode 0 only)
//   data_in               write data
//   empty, almost_empty, half_full, almost_full, full   occupancy flags
//   error                 overflow/underflow indication (sticky or per-cycle, see err_mode)
//   data_out              word at the head of the queue (qualify with ~empty)
module dw_fifo_s1_sf #(
    parameter int width    = 32,
    parameter int depth    = 4,
    parameter int ae_level = 1,
    parameter int af_level = 1,
    parameter int err_mode = 2,
    parameter int rst_mode = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_req_n,
    input  logic             pop_req_n,
    input  logic             diag_n,
    input  logic [width-1:0] data_in,
    output logic             empty,
    output logic             almost_empty,
    output logic             half_full,
    output logic             almost_full,
    output logic             full,
    output logic             error,
    output logic [width-1:0] data_out
);

    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(depth);
    localparam logic [CW-1:0] CNT_AE   = CW'(ae_level);
    localparam logic [CW-1:0] CNT_HF   = CW'((depth + 1) / 2);
    localparam logic [CW-1:0] CNT_AF   = CW'(depth - af_level);
    localparam logic [AW-1:0] PTR_LAST = AW'(depth - 1);

    logic [width-1:0] mem_q [depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;

    logic push_ok;
    logic pop_ok;
    logic violation;

    // Acceptance is judged on the registered occupancy only, so a pop in the
    // same cycle never frees a slot for a push when full.
    assign push_ok   = ~push_req_n && (cnt_q != CNT_FULL);
    assign pop_ok    = ~pop_req_n  && (cnt_q != '0);
    assign violation = (~push_req_n && (cnt_q == CNT_FULL)) ||
                       (~pop_req_n  && (cnt_q == '0));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        // Explicit wrap keeps non-power-of-two depths inside the array.
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (err_mode == 2) begin
            err_d = violation;
        end else if ((err_mode == 0) && !diag_n) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q | violation;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    generate
        if ((rst_mode % 2) == 0) begin : g_mem_rst
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < depth; i++) begin
                        mem_q[i] <= '0;
                    end
                end else if (push_ok) begin
                    mem_q[wr_ptr_q] <= data_in;
                end
            end
        end else begin : g_mem_nrst
            // Storage left uninitialised; reset still blocks the write.
            always_ff @(posedge clock) begin
                if (!reset && push_ok) begin
                    mem_q[wr_ptr_q] <= data_in;
                end
            end
        end
    endgenerate

    assign empty        = (cnt_q == '0);
    assign almost_empty = (cnt_q <= CNT_AE);
    assign half_full    = (cnt_q >= CNT_HF);
    assign almost_full  = (cnt_q >= CNT_AF);
    assign full         = (cnt_q == CNT_FULL);
    assign error        = err_q;
    assign data_out     = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_dw_fifo_s1_sf.sv
module tb_dw_fifo_s1_sf;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int AE    = 1;
    localparam int AF    = 1;

    logic         clock;
    logic         reset;
    logic         push_req_n;
    logic         pop_req_n;
    logic         diag_n;
    logic [W-1:0] data_in;
    logic         empty;
    logic         almost_empty;
    logic         half_full;
    logic         almost_full;
    logic         full;
    logic         error;
    logic [W-1:0] data_out;

    int n_checks;
    int n_errors;

    // Reference model: the queue contents plus the expected error bit.
    logic [W-1:0] model_q[$];
    logic         model_err;

    dw_fifo_s1_sf #(
        .width(W), .depth(DEPTH), .ae_level(AE), .af_level(AF),
        .err_mode(2), .rst_mode(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .push_req_n(push_req_n),
        .pop_req_n(pop_req_n),
        .diag_n(diag_n),
        .data_in(data_in),
        .empty(empty),
        .almost_empty(almost_empty),
        .half_full(half_full),
        .almost_full(almost_full),
        .full(full),
        .error(error),
        .data_out(data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model across the edge, then
    // compare every output against the model just after the edge.
    task automatic step(input logic rst, input logic push, input logic pop, input logic [W-1:0] din);
        int  sz;
        logic ovf, unf;
        reset      = rst;
        push_req_n = ~push;
        pop_req_n  = ~pop;
        data_in    = din;
        @(posedge clock);
        sz = model_q.size();
        if (rst) begin
            model_q.delete();
            model_err = 1'b0;
        end else begin
            ovf = push && (sz == DEPTH);
            unf = pop && (sz == 0);
            if (pop && sz > 0) void'(model_q.pop_front());
            if (push && sz < DEPTH) model_q.push_back(din);
            model_err = ovf | unf;
        end
        #1;
        sz = model_q.size();
        check("empty",        W'(empty),        W'(sz == 0));
        check("almost_empty", W'(almost_empty), W'(sz <= AE));
        check("half_full",    W'(half_full),    W'(sz >= (DEPTH + 1) / 2));
        check("almost_full",  W'(almost_full),  W'(sz >= DEPTH - AF));
        check("full",         W'(full),         W'(sz == DEPTH));
        check("error",        W'(error),        W'(model_err));
        if (sz > 0) check("data_out", data_out, model_q[0]);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        model_err  = 1'b0;
        reset      = 1'b1;
        push_req_n = 1'b1;
        pop_req_n  = 1'b1;
        diag_n     = 1'b1;
        data_in    = '0;

        // Reset, then idle.
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);

        // Fill to full.
        step(0, 1, 0, 32'h1111_1111);
        step(0, 1, 0, 32'h2222_2222);
        step(0, 1, 0, 32'h3333_3333);
        step(0, 1, 0, 32'h4444_4444);

        // Overflow push alone, then push+pop while full.
        step(0, 1, 0, 32'h0000_0055);
        step(0, 0, 0, '0);
        step(0, 1, 1, 32'h0000_0066);
        check("head_after_full_pushpop", data_out, 32'h2222_2222);
        step(0, 0, 0, '0);

        // Drain to empty and underflow once.
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, '0);
        step(0, 0, 1, '0);
        check("underflow_err", W'(error), W'(1));
        step(0, 0, 0, '0);
        check("underflow_err_clear", W'(error), W'(0));

        // Steady push+pop at occupancy 2 across pointer wrap.
        step(0, 1, 0, 32'hC000_0000);
        step(0, 1, 0, 32'hC000_0001);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 32'hC000_0002 + W'(i));

        // Reset mid-stream at occupancy 3, then a single push.
        step(0, 1, 0, 32'hDEAD_BEEF);
        step(1, 0, 0, '0);
        step(0, 1, 0, 32'hA5A5_A5A5);
        check("post_reset_head", data_out, 32'hA5A5_A5A5);
        step(0, 0, 0, '0);

        // Randomised phases, alternating fill-biased and drain-biased traffic.
        for (int ph = 0; ph < 8; ph++) begin
            int pp, pq;
            pp = (ph % 2 == 0) ? 75 : 30;
            pq = (ph % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 60; i++) begin
                step($urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < pp,
                     $urandom_range(0, 99) < pq,
                     $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
